// File: rtl/axi_master_arbiter.sv
// Shares the single network master port between MASTER_NUMBER requesters.
// Write and read channels each run an independent round-robin grant FSM.

module arb_req_buf #(
    parameter int PW = 32
) (
    input  logic          gclk,
    input  logic          grst_n,
    input  logic          start,
    input  logic          clear,
    input  logic [PW-1:0] payload,
    output logic          busy,
    output logic [PW-1:0] payload_q
);
    // A start while occupied is dropped so the in-flight request never changes.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            busy      <= 1'b0;
            payload_q <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            busy      <= 1'b1;
            payload_q <= payload;
        end
    end
endmodule

module arb_channel #(
    parameter int N              = 3,
    parameter int PW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 gclk,
    input  logic                 grst_n,
    input  logic [N-1:0]         busy,
    input  logic [N-1:0][PW-1:0] payload,
    input  logic                 net_cts,
    input  logic                 net_done,
    input  logic                 net_error,
    output logic                 net_start,
    output logic [PW-1:0]        net_payload,
    output logic [N-1:0]         clear,
    output logic [N-1:0]         done,
    output logic [N-1:0]         error
);
    localparam int GW      = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, last_q, last_d, cand;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     done_d, error_d;
    logic             found, timeout;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            cnt_q   <= '0;
            done    <= '0;
            error   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done    <= done_d;
            error   <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        net_start   = 1'b0;
        net_payload = '0;
        clear       = '0;
        done_d      = '0;
        error_d     = '0;
        found       = 1'b0;
        cand        = '0;
        timeout     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
        case (state_q)
            IDLE: begin
                // Scan starting just past the last served requester.
                for (int i = 1; i <= N; i++) begin
                    cand = GW'((int'(last_q) + i) % N);
                    if (!found && busy[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                net_payload = payload[grant_q];
                net_start   = net_cts;
                if (net_cts) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                net_payload = payload[grant_q];
                cnt_d       = cnt_q + CNT_W'(1);
                // A real done wins over a coincident watchdog expiry.
                if (net_done || timeout) begin
                    clear[grant_q]   = 1'b1;
                    done_d[grant_q]  = 1'b1;
                    error_d[grant_q] = net_done ? net_error : 1'b1;
                    last_d           = grant_q;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

module axi_master_arbiter #(
    parameter int MASTER_NUMBER  = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            axi_ACLK,
    input  logic                            axi_ARESETN,
    input  logic [MASTER_NUMBER-1:0]        req_write_start_i,
    input  logic [MASTER_NUMBER-1:0][31:0]  req_write_address_i,
    input  logic [MASTER_NUMBER-1:0][31:0]  req_write_data_i,
    input  logic [MASTER_NUMBER-1:0][3:0]   req_write_strobe_i,
    output logic [MASTER_NUMBER-1:0]        req_write_busy_o,
    output logic [MASTER_NUMBER-1:0]        req_write_done_o,
    output logic [MASTER_NUMBER-1:0]        req_write_error_o,
    input  logic [MASTER_NUMBER-1:0]        req_read_start_i,
    input  logic [MASTER_NUMBER-1:0][31:0]  req_read_address_i,
    output logic [MASTER_NUMBER-1:0]        req_read_busy_o,
    output logic [MASTER_NUMBER-1:0]        req_read_done_o,
    output logic [MASTER_NUMBER-1:0]        req_read_error_o,
    output logic [31:0]                     req_read_data_o,
    output logic                            net_write_start_o,
    output logic [31:0]                     net_write_address_o,
    output logic [31:0]                     net_write_data_o,
    output logic [3:0]                      net_write_strobe_o,
    input  logic                            net_write_cts_i,
    input  logic                            net_write_done_i,
    input  logic                            net_write_error_i,
    output logic                            net_read_start_o,
    output logic [31:0]                     net_read_address_o,
    input  logic                            net_read_cts_i,
    input  logic                            net_read_done_i,
    input  logic                            net_read_error_i,
    input  logic [31:0]                     net_read_data_i
);
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

    localparam int WPW = $bits(wr_req_t);

    logic [MASTER_NUMBER-1:0][WPW-1:0] wr_pl, wr_pl_q;
    logic [MASTER_NUMBER-1:0][31:0]    rd_pl_q;
    logic [MASTER_NUMBER-1:0]          wr_clear, rd_clear;
    logic [WPW-1:0]                    net_wr_pl;
    wr_req_t                           net_wr;
    logic                              rd_take;

    generate
        for (genvar k = 0; k < MASTER_NUMBER; k++) begin : g_req
            assign wr_pl[k] = {req_write_address_i[k], req_write_data_i[k], req_write_strobe_i[k]};

            arb_req_buf #(.PW(WPW)) u_wr_buf (
                .gclk(axi_ACLK), .grst_n(axi_ARESETN),
                .start(req_write_start_i[k]), .clear(wr_clear[k]),
                .payload(wr_pl[k]), .busy(req_write_busy_o[k]), .payload_q(wr_pl_q[k])
            );

            arb_req_buf #(.PW(32)) u_rd_buf (
                .gclk(axi_ACLK), .grst_n(axi_ARESETN),
                .start(req_read_start_i[k]), .clear(rd_clear[k]),
                .payload(req_read_address_i[k]), .busy(req_read_busy_o[k]), .payload_q(rd_pl_q[k])
            );
        end
    endgenerate

    arb_channel #(.N(MASTER_NUMBER), .PW(WPW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_ch (
        .gclk(axi_ACLK), .grst_n(axi_ARESETN),
        .busy(req_write_busy_o), .payload(wr_pl_q),
        .net_cts(net_write_cts_i), .net_done(net_write_done_i), .net_error(net_write_error_i),
        .net_start(net_write_start_o), .net_payload(net_wr_pl),
        .clear(wr_clear), .done(req_write_done_o), .error(req_write_error_o)
    );

    arb_channel #(.N(MASTER_NUMBER), .PW(32), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_ch (
        .gclk(axi_ACLK), .grst_n(axi_ARESETN),
        .busy(req_read_busy_o), .payload(rd_pl_q),
        .net_cts(net_read_cts_i), .net_done(net_read_done_i), .net_error(net_read_error_i),
        .net_start(net_read_start_o), .net_payload(net_read_address_o),
        .clear(rd_clear), .done(req_read_done_o), .error(req_read_error_o)
    );

    assign net_wr              = wr_req_t'(net_wr_pl);
    assign net_write_address_o = net_wr.addr;
    assign net_write_data_o    = net_wr.data;
    assign net_write_strobe_o  = net_wr.strb;

    // Clear only fires in WAIT, and a present done_i always takes priority
    // over the watchdog, so this marks network-completed reads only.
    assign rd_take = net_read_done_i && (|rd_clear);

    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN)  req_read_data_o <= '0;
        else if (rd_take)  req_read_data_o <= net_read_data_i;
    end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: write, round-robin reads,
// backpressure, error/timeout and reset during an outstanding read.

module tb_axi_master_arbiter;
    localparam int N  = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        wst, rst_s;
    logic [N-1:0][31:0]  wa, wd, ra;
    logic [N-1:0][3:0]   ws;
    logic [N-1:0]        req_write_busy_o, req_write_done_o, req_write_error_o;
    logic [N-1:0]        req_read_busy_o, req_read_done_o, req_read_error_o;
    logic [31:0]         req_read_data_o;
    logic                net_write_start_o, net_read_start_o;
    logic [31:0]         net_write_address_o, net_write_data_o, net_read_address_o;
    logic [3:0]          net_write_strobe_o;
    logic                wcts, wdone, werr, rcts, rdone, rerr;
    logic [31:0]         rdat;

    int n_chk  = 0;
    int n_fail = 0;

    axi_master_arbiter #(.MASTER_NUMBER(N), .TIMEOUT_CYCLES(TO)) dut (
        .axi_ACLK(clk), .axi_ARESETN(rst_n),
        .req_write_start_i(wst), .req_write_address_i(wa), .req_write_data_i(wd),
        .req_write_strobe_i(ws), .req_write_busy_o(req_write_busy_o),
        .req_write_done_o(req_write_done_o), .req_write_error_o(req_write_error_o),
        .req_read_start_i(rst_s), .req_read_address_i(ra),
        .req_read_busy_o(req_read_busy_o), .req_read_done_o(req_read_done_o),
        .req_read_error_o(req_read_error_o), .req_read_data_o(req_read_data_o),
        .net_write_start_o(net_write_start_o), .net_write_address_o(net_write_address_o),
        .net_write_data_o(net_write_data_o), .net_write_strobe_o(net_write_strobe_o),
        .net_write_cts_i(wcts), .net_write_done_i(wdone), .net_write_error_i(werr),
        .net_read_start_o(net_read_start_o), .net_read_address_o(net_read_address_o),
        .net_read_cts_i(rcts), .net_read_done_i(rdone), .net_read_error_i(rerr),
        .net_read_data_i(rdat)
    );

    // Inputs change 1 time unit after the rising edge; checks sit 2 units later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wst = '0; rst_s = '0; wa = '0; wd = '0; ws = '0; ra = '0;
        wcts = 1'b1; wdone = 1'b0; werr = 1'b0;
        rcts = 1'b1; rdone = 1'b0; rerr = 1'b0; rdat = '0;
        nxt(); wst = 3'b111; rst_s = 3'b111;
        nxt(); #2;
        n_chk++; if (req_write_busy_o !== 3'b000) begin n_fail++; $display("FAIL rst_wbusy got %b exp 000", req_write_busy_o); end
        n_chk++; if (req_read_busy_o !== 3'b000) begin n_fail++; $display("FAIL rst_rbusy got %b exp 000", req_read_busy_o); end
        n_chk++; if ({req_write_done_o, req_read_done_o, req_write_error_o, req_read_error_o} !== 12'h0) begin n_fail++; $display("FAIL rst_done_err got %h exp 0", {req_write_done_o, req_read_done_o, req_write_error_o, req_read_error_o}); end
        n_chk++; if (req_read_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", req_read_data_o); end
        n_chk++; if ({net_write_start_o, net_read_start_o} !== 2'b00) begin n_fail++; $display("FAIL rst_net_start got %b exp 00", {net_write_start_o, net_read_start_o}); end
        n_chk++; if ({net_write_address_o, net_write_data_o, net_write_strobe_o, net_read_address_o} !== 100'h0) begin n_fail++; $display("FAIL rst_net_fields got %h exp 0", {net_write_address_o, net_write_data_o, net_write_strobe_o, net_read_address_o}); end
        nxt(); wst = '0; rst_s = '0; rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        wa[0] = 32'h0000_0011; wa[2] = 32'h0000_0022;
        wa[1] = 32'h1000_0004; wd[1] = 32'hDEAD_BEEF; ws[1] = 4'hF;
        nxt(); wst = 3'b010; #2;
        n_chk++; if (req_write_busy_o !== 3'b000) begin n_fail++; $display("FAIL sw_busy_t0 got %b exp 000", req_write_busy_o); end
        nxt(); wst = '0; #2;
        n_chk++; if (req_write_busy_o !== 3'b010) begin n_fail++; $display("FAIL sw_busy_t1 got %b exp 010", req_write_busy_o); end
        n_chk++; if (net_write_start_o !== 1'b0) begin n_fail++; $display("FAIL sw_start_t1 got %b exp 0", net_write_start_o); end
        nxt(); #2;
        n_chk++; if (net_write_start_o !== 1'b1) begin n_fail++; $display("FAIL sw_start_t2 got %b exp 1", net_write_start_o); end
        n_chk++; if (net_write_address_o !== 32'h1000_0004) begin n_fail++; $display("FAIL sw_addr got %h exp 10000004", net_write_address_o); end
        n_chk++; if (net_write_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_data got %h exp deadbeef", net_write_data_o); end
        n_chk++; if (net_write_strobe_o !== 4'hF) begin n_fail++; $display("FAIL sw_strobe got %h exp f", net_write_strobe_o); end
        nxt(); #2;
        n_chk++; if (net_write_start_o !== 1'b0) begin n_fail++; $display("FAIL sw_start_t3 got %b exp 0", net_write_start_o); end
        n_chk++; if (net_write_address_o !== 32'h1000_0004) begin n_fail++; $display("FAIL sw_addr_hold got %h exp 10000004", net_write_address_o); end
        nxt();
        nxt(); wdone = 1'b1; #2;
        n_chk++; if (req_write_done_o !== 3'b000) begin n_fail++; $display("FAIL sw_done_early got %b exp 000", req_write_done_o); end
        nxt(); wdone = 1'b0; #2;
        n_chk++; if (req_write_done_o !== 3'b010) begin n_fail++; $display("FAIL sw_done got %b exp 010", req_write_done_o); end
        n_chk++; if (req_write_error_o !== 3'b000) begin n_fail++; $display("FAIL sw_err got %b exp 000", req_write_error_o); end
        n_chk++; if (req_write_busy_o !== 3'b000) begin n_fail++; $display("FAIL sw_busy_end got %b exp 000", req_write_busy_o); end
        n_chk++; if (net_write_address_o !== 32'h0) begin n_fail++; $display("FAIL sw_idle_addr got %h exp 0", net_write_address_o); end
        nxt(); #2;
        n_chk++; if (req_write_done_o !== 3'b000) begin n_fail++; $display("FAIL sw_done_pulse got %b exp 000", req_write_done_o); end
    endtask

    task automatic do_read(input int g, input logic [31:0] dat);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
            nxt(); #2; n++;
            seen = net_read_start_o;
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL rd%0d_start got none in 20 cycles exp pulse", g); end
        n_chk++; if (net_read_address_o !== ra[g]) begin n_fail++; $display("FAIL rd%0d_addr got %h exp %h", g, net_read_address_o, ra[g]); end
        nxt(); rdone = 1'b1; rdat = dat;
        nxt(); rdone = 1'b0; rdat = '0; #2;
        n_chk++; if (req_read_done_o !== 3'(1 << g)) begin n_fail++; $display("FAIL rd%0d_done got %b exp %b", g, req_read_done_o, 3'(1 << g)); end
        n_chk++; if (req_read_data_o !== dat) begin n_fail++; $display("FAIL rd%0d_data got %h exp %h", g, req_read_data_o, dat); end
        n_chk++; if (req_read_error_o !== 3'b000) begin n_fail++; $display("FAIL rd%0d_err got %b exp 000", g, req_read_error_o); end
        n_chk++; if (req_read_busy_o[g] !== 1'b0) begin n_fail++; $display("FAIL rd%0d_busy got %b exp 0", g, req_read_busy_o[g]); end
    endtask

    task automatic test_round_robin();
        ra[0] = 32'h0000_0100; ra[1] = 32'h0000_0200; ra[2] = 32'h0000_0300;
        nxt(); rst_s = 3'b111;
        nxt(); rst_s = '0; #2;
        n_chk++; if (req_read_busy_o !== 3'b111) begin n_fail++; $display("FAIL rr_busy got %b exp 111", req_read_busy_o); end
        do_read(0, 32'hA0);
        do_read(1, 32'hA1);
        do_read(2, 32'hA2);
        nxt(); rst_s = 3'b101;
        nxt(); rst_s = '0;
        do_read(0, 32'hB0);
        do_read(2, 32'hB2);
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        wa[2] = 32'h2000_0008; wd[2] = 32'h1234_5678; ws[2] = 4'h3;
        wcts = 1'b0;
        nxt(); wst = 3'b100;
        nxt(); wst = '0; #2;
        n_chk++; if (req_write_busy_o !== 3'b100) begin n_fail++; $display("FAIL bp_busy got %b exp 100", req_write_busy_o); end
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (i == 4) begin
                wst = 3'b100; wa[2] = 32'h0000_0BAD; wd[2] = 32'h0; ws[2] = 4'hC;
            end else begin
                wst = '0;
            end
            #2;
            if (net_write_start_o) pulses++;
            n_chk++; if ({net_write_address_o, net_write_data_o, net_write_strobe_o} !== {32'h2000_0008, 32'h1234_5678, 4'h3}) begin n_fail++; $display("FAIL bp_stable%0d got %h exp %h", i, {net_write_address_o, net_write_data_o, net_write_strobe_o}, {32'h2000_0008, 32'h1234_5678, 4'h3}); end
        end
        nxt(); wst = '0; wcts = 1'b1; #2;
        if (net_write_start_o) pulses++;
        n_chk++; if (net_write_start_o !== 1'b1) begin n_fail++; $display("FAIL bp_start got %b exp 1", net_write_start_o); end
        nxt(); #2;
        if (net_write_start_o) pulses++;
        n_chk++; if (net_write_address_o !== 32'h2000_0008) begin n_fail++; $display("FAIL bp_addr_wait got %h exp 20000008", net_write_address_o); end
        nxt(); wdone = 1'b1;
        nxt(); wdone = 1'b0; #2;
        n_chk++; if (req_write_done_o !== 3'b100) begin n_fail++; $display("FAIL bp_done got %b exp 100", req_write_done_o); end
        for (int i = 0; i < 3; i++) begin
            nxt(); #2;
            if (net_write_start_o) pulses++;
        end
        n_chk++; if (req_write_busy_o !== 3'b000) begin n_fail++; $display("FAIL bp_dup_latched got %b exp 000", req_write_busy_o); end
        n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL bp_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_error_timeout();
        int early = 0;
        wa[0] = 32'h0000_0040;
        nxt(); wst = 3'b001;
        nxt(); wst = '0;
        nxt(); #2;
        n_chk++; if (net_write_start_o !== 1'b1) begin n_fail++; $display("FAIL err_start got %b exp 1", net_write_start_o); end
        nxt(); wdone = 1'b1; werr = 1'b1;
        nxt(); wdone = 1'b0; werr = 1'b0; #2;
        n_chk++; if (req_write_done_o !== 3'b001) begin n_fail++; $display("FAIL err_done got %b exp 001", req_write_done_o); end
        n_chk++; if (req_write_error_o !== 3'b001) begin n_fail++; $display("FAIL err_flag got %b exp 001", req_write_error_o); end

        // Read with no done: watchdog counts 0..7 over the 8 WAIT cycles.
        ra[1] = 32'h0000_5000;
        nxt(); rst_s = 3'b010;
        nxt(); rst_s = '0;
        nxt(); #2;
        n_chk++; if (net_read_start_o !== 1'b1) begin n_fail++; $display("FAIL to_start got %b exp 1", net_read_start_o); end
        for (int i = 1; i <= 8; i++) begin
            nxt(); #2;
            if (req_read_done_o !== 3'b000) early++;
        end
        n_chk++; if (early !== 0) begin n_fail++; $display("FAIL to_early got %0d done cycles exp 0", early); end
        nxt(); #2;
        n_chk++; if (req_read_done_o !== 3'b010) begin n_fail++; $display("FAIL to_done got %b exp 010", req_read_done_o); end
        n_chk++; if (req_read_error_o !== 3'b010) begin n_fail++; $display("FAIL to_err got %b exp 010", req_read_error_o); end
        n_chk++; if (req_read_data_o !== 32'hB2) begin n_fail++; $display("FAIL to_data got %h exp b2", req_read_data_o); end
        nxt();
        nxt(); rdone = 1'b1; rdat = 32'h0000_0BAD;
        nxt(); rdone = 1'b0; rdat = '0; #2;
        n_chk++; if (req_read_done_o !== 3'b000) begin n_fail++; $display("FAIL to_late_done got %b exp 000", req_read_done_o); end
        n_chk++; if (req_read_data_o !== 32'hB2) begin n_fail++; $display("FAIL to_late_data got %h exp b2", req_read_data_o); end
    endtask

    task automatic test_reset_wait();
        ra[0] = 32'h0000_7000; wa[1] = 32'h0000_8000;
        nxt(); rst_s = 3'b001; wst = 3'b010;
        nxt(); rst_s = '0; wst = '0;
        nxt();
        nxt(); #2;
        n_chk++; if (net_read_address_o !== 32'h0000_7000) begin n_fail++; $display("FAIL rw_pre_addr got %h exp 7000", net_read_address_o); end
        rst_n = 1'b0; #1;
        n_chk++; if ({req_read_busy_o, req_write_busy_o} !== 6'b0) begin n_fail++; $display("FAIL rw_busy got %b exp 0", {req_read_busy_o, req_write_busy_o}); end
        n_chk++; if ({net_read_address_o, net_write_address_o} !== 64'h0) begin n_fail++; $display("FAIL rw_addr got %h exp 0", {net_read_address_o, net_write_address_o}); end
        n_chk++; if (req_read_data_o !== 32'h0) begin n_fail++; $display("FAIL rw_rdata got %h exp 0", req_read_data_o); end
        n_chk++; if ({net_read_start_o, net_write_start_o} !== 2'b00) begin n_fail++; $display("FAIL rw_start got %b exp 00", {net_read_start_o, net_write_start_o}); end
        nxt(); rdone = 1'b1; wdone = 1'b1;
        nxt(); rst_n = 1'b1;
        nxt(); rdone = 1'b0; wdone = 1'b0; #2;
        n_chk++; if ({req_read_done_o, req_write_done_o} !== 6'b0) begin n_fail++; $display("FAIL rw_stale_done got %b exp 0", {req_read_done_o, req_write_done_o}); end
        ra[0] = 32'h0000_0100; ra[2] = 32'h0000_0300;
        nxt(); rst_s = 3'b101;
        nxt(); rst_s = '0;
        nxt(); #2;
        n_chk++; if (net_read_start_o !== 1'b1) begin n_fail++; $display("FAIL rw_tie_start got %b exp 1", net_read_start_o); end
        n_chk++; if (net_read_address_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rw_tie_grant got %h exp 100", net_read_address_o); end
        nxt(); rdone = 1'b1; rdat = 32'hC0;
        nxt(); rdone = 1'b0; rdat = '0; #2;
        n_chk++; if (req_read_done_o !== 3'b001) begin n_fail++; $display("FAIL rw_tie_done got %b exp 001", req_read_done_o); end
        do_read(2, 32'hC2);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_error_timeout();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish exp finish before 100000");
        $fatal(1);
    end
endmodule
